// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: FSM encoding and channel indices.
package perf_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } perf_state_e;

    localparam int CH_CYCLE  = 0;
    localparam int CH_UNCOND = 1;
    localparam int CH_COND   = 2;
    localparam int CH_TAKEN  = 3;
    localparam int CH_LDUSE  = 4;

endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: live count, shadow copy and sticky overflow flag.
module perf_counter_cell #(
    parameter int CNT_W = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             snap_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] shadow_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        // Shadow always captures the pre-edge value, so clr/inc on the same edge do not leak in.
        shadow_d = snap_i ? cnt_q : shadow_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            ovf_d = ovf_q | at_max;
            cnt_d = (at_max && SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign shadow_o = shadow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus NUM_CH event counters with halt freeze, atomic snapshot and registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter bit SAT    = 1'b0,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              halt,
    input  logic              clr,
    input  logic              snap,
    input  logic [NUM_CH-1:0] ev,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              rd_shadow,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic              frozen
);

    perf_state_e state_q, state_d;
    logic        count_en;
    logic        auto_snap;
    logic        snap_take;

    logic [NUM_CH:0]            inc;
    logic [NUM_CH:0][CNT_W-1:0] cnt;
    logic [NUM_CH:0][CNT_W-1:0] shd;
    logic [CNT_W-1:0]           rd_data_q, rd_data_d;

    always_comb begin
        state_d   = state_q;
        count_en  = 1'b0;
        auto_snap = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d   = ST_FROZEN;
                    auto_snap = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            ST_FROZEN: begin
                if (!halt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    assign snap_take     = snap | auto_snap;
    assign inc[0]        = count_en;
    assign inc[NUM_CH:1] = ev & {NUM_CH{count_en}};

    for (genvar k = 0; k <= NUM_CH; k++) begin : g_cell
        perf_counter_cell #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cell (
            .clk      (clk),
            .RST      (RST),
            .inc_i    (inc[k]),
            .clr_i    (clr),
            .snap_i   (snap_take),
            .cnt_o    (cnt[k]),
            .shadow_o (shd[k]),
            .ovf_o    (ovf[k])
        );
    end

    // Unmatched selects (rd_sel > NUM_CH) fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k <= NUM_CH; k++) begin
            if (rd_sel == SEL_W'(k)) rd_data_d = rd_shadow ? shd[k] : cnt[k];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
    assign frozen  = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Drives a wrapping and a saturating 8-bit bank with identical stimulus and checks both against a reference model.
module tb_perf_counter_bank;

    localparam int NCH  = 4;
    localparam int W    = 8;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           RST, halt, clr, snap, rd_shadow;
    logic [NCH-1:0] ev;
    logic [3:0]     rd_sel;
    logic [W-1:0]   rd0, rd1;
    logic [NCH:0]   ovf0, ovf1;
    logic           frz0, frz1;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SAT(1'b0), .SEL_W(4)) u_wrap (
        .clk(clk), .RST(RST), .halt(halt), .clr(clr), .snap(snap), .ev(ev),
        .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd0), .ovf(ovf0), .frozen(frz0)
    );

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SAT(1'b1), .SEL_W(4)) u_sat (
        .clk(clk), .RST(RST), .halt(halt), .clr(clr), .snap(snap), .ev(ev),
        .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd1), .ovf(ovf1), .frozen(frz1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 = wrapping bank, 1 = saturating bank.
    int live [2][NCH+1];
    int shd  [2][NCH+1];
    bit ovm  [2][NCH+1];
    int rd_m [2];
    bit frz_m;

    function automatic int ovf_exp(input int d);
        int v = 0;
        for (int k = 0; k <= NCH; k++) if (ovm[d][k]) v += (1 << k);
        return v;
    endfunction

    task automatic model_edge();
        bit take, bump;
        if (RST) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k <= NCH; k++) begin
                    live[d][k] = 0; shd[d][k] = 0; ovm[d][k] = 1'b0;
                end
                rd_m[d] = 0;
            end
            frz_m = 1'b0;
            return;
        end
        take = snap || (!frz_m && halt);
        for (int d = 0; d < 2; d++) begin
            rd_m[d] = (rd_sel > NCH) ? 0 : (rd_shadow ? shd[d][rd_sel] : live[d][rd_sel]);
            for (int k = 0; k <= NCH; k++) begin
                if (take) shd[d][k] = live[d][k];
                bump = !frz_m && !halt && ((k == 0) ? 1'b1 : ev[k-1]);
                if (clr) begin
                    live[d][k] = 0;
                    ovm[d][k]  = 1'b0;
                end else if (bump) begin
                    if (live[d][k] == MAXV) begin
                        ovm[d][k]  = 1'b1;
                        live[d][k] = (d == 1) ? MAXV : 0;
                    end else begin
                        live[d][k] = live[d][k] + 1;
                    end
                end
            end
        end
        frz_m = halt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_wrap",    32'(rd0),  32'(rd_m[0]));
        chk("rd_sat",     32'(rd1),  32'(rd_m[1]));
        chk("ovf_wrap",   32'(ovf0), 32'(ovf_exp(0)));
        chk("ovf_sat",    32'(ovf1), 32'(ovf_exp(1)));
        chk("frozen",     32'(frz0), 32'(frz_m));
        chk("frozen_sat", 32'(frz1), 32'(frz_m));
    endtask

    task automatic idle();
        RST = 1'b0; halt = 1'b0; clr = 1'b0; snap = 1'b0;
        ev = '0; rd_sel = '0; rd_shadow = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        ev  = '1;

        // T1: reset with events asserted, then 10 run edges
        step(); step();
        chk("t1_rst_rd",  32'(rd0),  0);
        chk("t1_rst_ovf", 32'(ovf0), 0);
        chk("t1_rst_frz", 32'(frz0), 0);
        idle();
        for (int i = 0; i < 11; i++) step();
        chk("t1_cyc10", 32'(rd0), 10);

        // T2: event channels
        do_reset();
        ev = 4'b0010;
        for (int i = 0; i < 7; i++) step();
        ev = 4'b0011;
        for (int i = 0; i < 3; i++) step();
        ev = '0;
        rd_sel = 4'd2; step(); step();
        chk("t2_ch2", 32'(rd0), 10);
        rd_sel = 4'd1; step(); step();
        chk("t2_ch1", 32'(rd0), 3);
        rd_sel = 4'd3; step(); step();
        chk("t2_ch3", 32'(rd0), 0);

        // T3: halt freeze and resume
        do_reset();
        for (int i = 0; i < 20; i++) step();
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ev = 4'($urandom);
            step();
        end
        ev = '0;
        chk("t3_frozen", 32'(frz0), 1);
        chk("t3_live",   32'(rd0),  20);
        rd_shadow = 1'b1; step();
        chk("t3_shadow", 32'(rd0), 20);
        rd_shadow = 1'b0; halt = 1'b0;
        step(); step(); step();
        chk("t3_resume", 32'(rd0), 21);

        // T4: overflow, wrap vs saturate, then clear
        do_reset();
        for (int i = 0; i < 256; i++) step();
        step();
        chk("t4_wrap_val",  32'(rd0),     0);
        chk("t4_wrap_ovf",  32'(ovf0[0]), 1);
        chk("t4_sat_val",   32'(rd1),     255);
        for (int i = 0; i < 43; i++) step();
        step();
        chk("t4_sat_300",   32'(rd1),     255);
        chk("t4_sat_ovf",   32'(ovf1[0]), 1);
        clr = 1'b1; step();
        clr = 1'b0;
        chk("t4_clr_ovf0", 32'(ovf0), 0);
        chk("t4_clr_ovf1", 32'(ovf1), 0);
        halt = 1'b1; step();
        chk("t4_clr_val", 32'(rd1), 0);
        halt = 1'b0;

        // T5: snap + clr + event on one edge
        do_reset();
        ev = 4'b0001;
        for (int i = 0; i < 41; i++) step();
        snap = 1'b1; clr = 1'b1; step();
        snap = 1'b0; clr = 1'b0;
        rd_sel = 4'd1; rd_shadow = 1'b1; step();
        chk("t5_shadow", 32'(rd0), 41);
        ev = '0; rd_shadow = 1'b0; step();
        chk("t5_live", 32'(rd0), 1);

        // T6: out-of-range select and mid-count reset
        rd_sel = 4'd7; step(); step();
        chk("t6_sel7", 32'(rd0), 0);
        do_reset();
        rd_sel = 4'd0;
        for (int i = 0; i < 99; i++) step();
        RST = 1'b1; step();
        RST = 1'b0;
        chk("t6_rst_rd", 32'(rd0), 0);
        halt = 1'b1; step();
        chk("t6_rst_live", 32'(rd0), 0);
        rd_shadow = 1'b1; step();
        chk("t6_rst_shadow", 32'(rd0), 0);
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            RST       = ($urandom_range(0, 199) == 0);
            halt      = ($urandom_range(0, 7) == 0);
            clr       = ($urandom_range(0, 31) == 0);
            snap      = ($urandom_range(0, 15) == 0);
            ev        = 4'($urandom);
            rd_sel    = 4'($urandom_range(0, 7));
            rd_shadow = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
